pw_conv_par_requant: RTL and testbench

Next-generation pointwise (1x1) convolution engine with NUM_PAR output-channel lanes computed in parallel from one shared input-activation stream. Channel and pixel sequencing is counted internally from start-time config; no first/last sideband. Q31 requantisation is built in, with optional ReLU6 clamp. Lanes are serialised onto a single int8 output stream. Sits after the depthwise stage in a depthwise-separable block, replacing the single-lane pointwise MAC plus external requant pair.

---
 rtl/pw_conv_par_requant.sv | 163 ++++++++++++++++
 tb/tb_pw_conv_par_requant.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_conv_par_requant.sv
// Pointwise (1x1) convolution with NUM_PAR parallel output-channel lanes, built-in
// Q31 requantisation with optional ReLU6 clamp, lanes serialised onto one int8 stream.
module pw_conv_par_requant #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 32,
  parameter int MUL_W     = 32,
  parameter int SHIFT_W   = 6,
  parameter int NUM_PAR   = 8,
  parameter int MAX_IN_CH = 1024,
  parameter int MAX_PIX   = 50176
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start,
  input  logic [$clog2(MAX_IN_CH+1)-1:0]                  cfg_in_ch,
  input  logic [$clog2(MAX_PIX+1)-1:0]                    cfg_num_pix,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic signed [DATA_W-1:0]                        in_data,
  input  logic signed [NUM_PAR*DATA_W-1:0]                weight_flat,
  input  logic signed [NUM_PAR*ACC_W-1:0]                 bias_flat,
  input  logic signed [MUL_W-1:0]                         mul_q31,
  input  logic [SHIFT_W-1:0]                              shift,
  input  logic signed [DATA_W-1:0]                        zp_out,
  input  logic signed [DATA_W-1:0]                        relu6_max,
  input  logic                                            relu6_en,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic signed [DATA_W-1:0]                        out_data,
  output logic [((NUM_PAR > 1) ? $clog2(NUM_PAR) : 1)-1:0] out_lane,
  output logic                                            busy,
  output logic                                            done,
  output logic [1:0]                                      dbg_state
);

  localparam int IN_CH_W = $clog2(MAX_IN_CH+1);
  localparam int PIX_W   = $clog2(MAX_PIX+1);
  localparam int LANE_W  = (NUM_PAR > 1) ? $clog2(NUM_PAR) : 1;
  localparam int RQ_W    = ACC_W + MUL_W;
  localparam logic signed [RQ_W-1:0] ONE      = RQ_W'(1);
  localparam logic signed [RQ_W-1:0] HALF_Q31 = RQ_W'(1) << 30;
  localparam logic [LANE_W:0]        NPAR     = (LANE_W+1)'(NUM_PAR);
  localparam logic [LANE_W-1:0]      LAST_L   = LANE_W'(NUM_PAR-1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_DRAIN = 2'd2} state_t;

  // Valid/ready: a transfer happens on any rising clk edge where valid && ready;
  // producers hold data stable while valid is high and ready is low.

  state_t state, state_nx;

  logic [IN_CH_W-1:0]      in_ch_q, ch_cnt;
  logic [PIX_W-1:0]        num_pix_q, pix_cnt;
  logic [LANE_W:0]         ld_cnt;
  logic signed [ACC_W-1:0] acc [NUM_PAR];

  logic signed [2*DATA_W-1:0] prod [NUM_PAR];
  logic signed [ACC_W-1:0]    prod_ext [NUM_PAR];

  logic in_hs, out_hs, last_ch, last_pix, load, drain_end;

  logic signed [ACC_W-1:0]  acc_sel;
  logic signed [RQ_W-1:0]   rq_p, rq_t, rq_rnd, rq_r, rq_y, rq_lo, rq_hi;
  logic signed [DATA_W-1:0] rq_out;

  assign dbg_state = state;
  assign busy      = (state != S_IDLE);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_ch   = (ch_cnt == in_ch_q - IN_CH_W'(1));
  assign last_pix  = (pix_cnt == num_pix_q - PIX_W'(1));
  // A lane is loaded whenever the output register is empty or being emptied this cycle.
  assign load      = (state == S_DRAIN) && (ld_cnt < NPAR) && (!out_valid || out_ready);
  assign drain_end = (state == S_DRAIN) && out_hs && (out_lane == LAST_L);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_ACCUM;
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_hs && last_ch) state_nx = S_DRAIN;
      end
      S_DRAIN: if (drain_end) state_nx = last_pix ? S_IDLE : S_ACCUM;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < NUM_PAR; k++) begin
      prod[k] = {{DATA_W{in_data[DATA_W-1]}}, in_data} *
                {{DATA_W{weight_flat[k*DATA_W+DATA_W-1]}}, weight_flat[k*DATA_W +: DATA_W]};
      prod_ext[k] = {{(ACC_W-2*DATA_W){prod[k][2*DATA_W-1]}}, prod[k]};
    end
  end

  // Requantisation of the lane about to be loaded into the output register.
  always_comb begin
    acc_sel = acc[ld_cnt[LANE_W-1:0]];
    rq_p    = {{MUL_W{acc_sel[ACC_W-1]}}, acc_sel} * {{ACC_W{mul_q31[MUL_W-1]}}, mul_q31};
    rq_t    = (rq_p + HALF_Q31) >>> 31;
    rq_rnd  = (shift != '0) ? (ONE <<< (shift - SHIFT_W'(1))) : '0;
    rq_r    = (rq_t + rq_rnd) >>> shift;
    rq_y    = rq_r + {{(RQ_W-DATA_W){zp_out[DATA_W-1]}}, zp_out};
    rq_lo   = relu6_en ? {{(RQ_W-DATA_W){zp_out[DATA_W-1]}}, zp_out}
                       : {{(RQ_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    rq_hi   = relu6_en ? {{(RQ_W-DATA_W){relu6_max[DATA_W-1]}}, relu6_max}
                       : {{(RQ_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    if (rq_y < rq_lo)      rq_out = rq_lo[DATA_W-1:0];
    else if (rq_y > rq_hi) rq_out = rq_hi[DATA_W-1:0];
    else                   rq_out = rq_y[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ch_q   <= '0;
      num_pix_q <= '0;
      ch_cnt    <= '0;
      pix_cnt   <= '0;
      ld_cnt    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= '0;
      done      <= 1'b0;
      for (int k = 0; k < NUM_PAR; k++) acc[k] <= '0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE && start) begin
        in_ch_q   <= cfg_in_ch;
        num_pix_q <= cfg_num_pix;
        ch_cnt    <= '0;
        pix_cnt   <= '0;
      end
      if (in_hs) begin
        ch_cnt <= last_ch ? '0 : ch_cnt + IN_CH_W'(1);
        if (last_ch) ld_cnt <= '0;
        for (int k = 0; k < NUM_PAR; k++) begin
          if (ch_cnt == '0) acc[k] <= bias_flat[k*ACC_W +: ACC_W] + prod_ext[k];
          else              acc[k] <= acc[k] + prod_ext[k];
        end
      end
      if (load) begin
        out_data  <= rq_out;
        out_lane  <= ld_cnt[LANE_W-1:0];
        out_valid <= 1'b1;
        ld_cnt    <= ld_cnt + (LANE_W+1)'(1);
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
      if (drain_end) begin
        if (last_pix) done <= 1'b1;
        else          pix_cnt <= pix_cnt + PIX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pw_conv_par_requant.sv
// Directed + randomised bench for pw_conv_par_requant with NUM_PAR=4; outputs are
// checked against an expected queue filled when each pixel's last channel is sent.
module tb_pw_conv_par_requant;
  localparam int NP = 4;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int LW = 2;

  logic clk, rst, start;
  logic [10:0] cfg_in_ch;
  logic [15:0] cfg_num_pix;
  logic in_valid, in_ready;
  logic signed [DW-1:0] in_data;
  logic signed [NP*DW-1:0] weight_flat;
  logic signed [NP*AW-1:0] bias_flat;
  logic signed [31:0] mul_q31;
  logic [5:0] shift;
  logic signed [DW-1:0] zp_out, relu6_max;
  logic relu6_en;
  logic out_valid, out_ready;
  logic signed [DW-1:0] out_data;
  logic [LW-1:0] out_lane;
  logic busy, done;
  logic [1:0] dbg_state;

  pw_conv_par_requant #(.NUM_PAR(NP)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_in_ch(cfg_in_ch), .cfg_num_pix(cfg_num_pix),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .weight_flat(weight_flat),
    .bias_flat(bias_flat), .mul_q31(mul_q31), .shift(shift), .zp_out(zp_out),
    .relu6_max(relu6_max), .relu6_en(relu6_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lane(out_lane), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [LW+DW-1:0] exp_q[$];
  int mode = 0;
  bit mon_en = 0;
  int out_cnt = 0, out_total = 0, done_cnt = 0;
  bit chk_next_done = 0, chk_next_inready = 0, prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic [LW-1:0] prev_lane;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // out_ready pattern: 0 always ready, 1 repeating 1,0,0,1, 2 never ready
  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (mode)
        0: out_ready = 1'b1;
        1: begin out_ready = ((ph % 4) == 0) || ((ph % 4) == 3); ph++; end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // scoreboard / protocol monitor
  initial begin
    logic [LW+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (chk_next_done) begin
          check("done_after_last", {done, busy}, 2'b10);
          chk_next_done = 0;
        end
        if (chk_next_inready) begin
          check("in_ready_after_drain", in_ready, 1'b1);
          chk_next_inready = 0;
        end
        if (done === 1'b1) done_cnt++;
        if (prev_stall) check("hold_while_stalled", {out_valid, out_lane, out_data},
                              {1'b1, prev_lane, prev_data});
        if (out_valid === 1'b1) check("in_ready_low_in_drain", in_ready, 1'b0);
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_lane  = out_lane;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", {out_lane, out_data}, '1);
          end else begin
            e = exp_q.pop_front();
            check("out_lane_data", {out_lane, out_data}, e);
          end
          out_cnt++;
          if (out_lane == LW'(NP-1)) begin
            if (out_cnt == out_total) chk_next_done = 1;
            else                      chk_next_inready = 1;
          end
        end
      end
    end
  end

  function automatic logic [DW-1:0] m_requant(int acc, int mul, int sh, int zp, int mx, bit en);
    longint p, t, r, y, lo, hi;
    p = longint'(acc) * longint'(mul);
    t = (p + 64'sd1073741824) >>> 31;
    r = (sh > 0) ? ((t + (64'sd1 <<< (sh - 1))) >>> sh) : t;
    y = r + longint'(zp);
    lo = en ? longint'(zp) : -64'sd128;
    hi = en ? longint'(mx) : 64'sd127;
    if (y < lo) y = lo;
    if (y > hi) y = hi;
    return y[DW-1:0];
  endfunction

  // driver tasks (entered and left just after a rising edge)
  task automatic do_start(input int nch, input int npix);
    cfg_in_ch = 11'(nch);
    cfg_num_pix = 16'(npix);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_ch(input logic [DW-1:0] d, input logic [NP*DW-1:0] wf,
                         input logic [NP*AW-1:0] bf);
    int n;
    bit hs;
    n = 0; hs = 0;
    in_valid = 1'b1; in_data = d; weight_flat = wf; bias_flat = bf;
    while (!hs && n < 200) begin
      @(negedge clk); hs = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("in_handshake_timeout", hs, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin @(posedge clk); #1; n++; end
    check("idle_timeout", busy, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic push4(input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                       input logic [DW-1:0] v2, input logic [DW-1:0] v3);
    exp_q.push_back({2'd0, v0});
    exp_q.push_back({2'd1, v1});
    exp_q.push_back({2'd2, v2});
    exp_q.push_back({2'd3, v3});
  endtask

  localparam logic [NP*AW-1:0] BIAS1 = {32'sd100, -32'sd10, 32'sd10, 32'sd0};

  initial begin
    int acc_m[NP];
    int wv[NP];
    int bv[NP];
    int d;
    logic [NP*DW-1:0] wf;
    logic [NP*AW-1:0] bf;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; weight_flat = '0;
    bias_flat = '0; cfg_in_ch = '0; cfg_num_pix = '0; mul_q31 = 32'h7FFF_FFFF; shift = '0;
    zp_out = '0; relu6_max = 8'sd127; relu6_en = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy_done", {busy, done}, 2'b00);
    check("rst_out", {out_lane, out_data}, '0);
    check("rst_state", dbg_state, 2'd0);
    @(posedge clk); #1;
    mon_en = 1;

    // basic 3-channel pixel, plus output latency
    mode = 0; out_cnt = 0; out_total = 4;
    do_start(3, 1);
    check("busy_after_start", busy, 1'b1);
    send_ch(8'sd1, 32'h01010101, BIAS1);
    send_ch(8'sd2, 32'h01010101, BIAS1);
    send_ch(8'sd3, 32'h01010101, BIAS1);
    push4(8'd6, 8'd16, 8'hFC, 8'd106);
    @(negedge clk); check("out_valid_lat1", out_valid, 1'b0);
    @(negedge clk); check("out_valid_lat2", out_valid, 1'b1);
    @(posedge clk); #1;
    wait_idle();

    // ReLU6 clamp into [-128, -90] with zp -128
    relu6_en = 1'b1; zp_out = -8'sd128; relu6_max = -8'sd90;
    out_cnt = 0; out_total = 4;
    do_start(3, 1);
    send_ch(8'sd1, 32'h01010101, BIAS1);
    send_ch(8'sd2, 32'h01010101, BIAS1);
    send_ch(8'sd3, 32'h01010101, BIAS1);
    push4(8'h86, 8'h90, 8'h80, 8'hA6);
    wait_idle();

    // rounding: mul 2^30, shift 2; acc = 100, -100, 7, 50
    relu6_en = 1'b0; zp_out = '0; relu6_max = 8'sd127;
    mul_q31 = 32'h4000_0000; shift = 6'd2;
    out_cnt = 0; out_total = 4;
    do_start(1, 1);
    send_ch(8'sd10, {8'sd5, 8'sd0, -8'sd10, 8'sd10}, {32'sd0, 32'sd7, 32'sd0, 32'sd0});
    push4(8'd13, 8'hF4, 8'd1, 8'd6);
    wait_idle();

    // 3 pixels x 4 channels, random data, stalling output, ignored mid-run start
    mul_q31 = 32'($urandom_range(32'h0100_0000, 32'h4000_0000));
    shift = 6'($urandom_range(0, 6));
    zp_out = 8'sd3;
    mode = 1; out_cnt = 0; out_total = 3 * NP;
    do_start(4, 3);
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 4; c++) begin
        d = $urandom_range(0, 200) - 100;
        for (int k = 0; k < NP; k++) begin
          wv[k] = $urandom_range(0, 254) - 127;
          bv[k] = $urandom_range(0, 4000) - 2000;
          wf[k*DW +: DW] = wv[k][DW-1:0];
          bf[k*AW +: AW] = bv[k];
          acc_m[k] = ((c == 0) ? bv[k] : acc_m[k]) + d * wv[k];
        end
        send_ch(d[DW-1:0], wf, bf);
        if (p == 0 && c == 0) begin
          do_start(1, 1);
          cfg_in_ch = 11'd4; cfg_num_pix = 16'd3;
        end
      end
      for (int k = 0; k < NP; k++)
        exp_q.push_back({LW'(k), m_requant(acc_m[k], int'(mul_q31), int'(shift), 3, 127, 1'b0)});
    end
    wait_idle();

    // reset while draining with output stalled
    mode = 2; mon_en = 0;
    mul_q31 = 32'h7FFF_FFFF; shift = '0; zp_out = '0;
    do_start(2, 1);
    send_ch(8'sd5, 32'h01010101, BIAS1);
    send_ch(8'sd5, 32'h01010101, BIAS1);
    repeat (3) begin @(posedge clk); #1; end
    check("drain_valid_before_rst", {out_valid, dbg_state}, {1'b1, 2'd2});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_state", dbg_state, 2'd0);
    check("midrst_flags", {in_ready, out_valid, busy, done}, 4'b0000);
    check("midrst_out", {out_lane, out_data}, '0);
    mode = 0;
    repeat (4) begin @(posedge clk); #1; end
    check("midrst_no_output", {out_valid, busy}, 2'b00);
    exp_q.delete();
    prev_stall = 0; chk_next_done = 0; chk_next_inready = 0;
    mon_en = 1;

    // single channel, saturating extremes
    out_cnt = 0; out_total = 4;
    do_start(1, 1);
    send_ch(8'h80, {8'h7F, 8'h80, 8'h7F, 8'h80}, '0);
    push4(8'd127, 8'h80, 8'd127, 8'h80);
    wait_idle();

    check("queue_empty", exp_q.size(), 0);
    check("done_count", done_cnt, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
